seq_controller_p: RTL and testbench
===================================

// Module: seq_controller_p
// PURPOSE
//  Parametrised sequence controller + phase generator for the RISC-Y datapath; next generation of Controller.
//  Steps each instruction through BOOT->FETCH->DECODE->EXEC->WBACK, decoding OPCODE/I_Flag/ALU_Flags into strobes.
//  Adds over Controller: memory wait-state handshake (MEM_RDY), wait timeout with sticky bus error, HALT state, status outputs.
// PARAMETERS
//  WAIT_LIMIT  15  max consecutive MEM_RDY=0 cycles in one memory phase before BUS_ERR; 0 = no timeout
//  USE_MEM_RDY 1   1: memory phases wait for MEM_RDY; 0: MEM_RDY treated as constant 1
//  CNT_W       $clog2(WAIT_LIMIT+1)  wait counter width (derived, do not override)
// PORTS
//  CLK        in   1  clock, rising edge
//  RST        in   1  asynchronous reset, active low
//  Ena        in   1  active-low run enable; 1 = freeze
//  OPCODE     in   4  opcode from IR (valid from DECODE onward)
//  I_Flag     in   1  immediate operand flag from IR
//  ALU_Flags  in   4  {C,V,N,Z} = bits [3:0]: C=3, V=2, N=1, Z=0
//  MEM_RDY    in   1  RAM access complete this cycle
//  IR_EN,A_EN,B_EN,PDR_EN,PORT_EN,PORT_RD,PC_EN,PC_LOAD,ALU_EN,ALU_OE,RAM_OE,RDR_EN,RAM_CS  out 1 each  datapath strobes
//  PHASE      out  3  current state code (risc_y_pkg::phase_t)
//  HALTED     out  1  in HALT state
//  BUS_ERR    out  1  sticky; wait timeout occurred
// BEHAVIOUR
//  Reset (RST=0, async): state=BOOT, wait cnt=0, BUS_ERR=0; every output 0 (PHASE=BOOT).
//  BOOT: all strobes 0; next FETCH. Reset mid-instruction aborts it; no strobe glitches while RST=0.
//  Strobes: Moore decode of state+OPCODE+I_Flag; IR_EN, RDR_EN and B_EN also gated by MEM_RDY. PHASE/HALTED/BUS_ERR are registered.
//  Ena=1: state and counter hold; all strobes forced 0; status outputs hold.
//  Memory phase = FETCH, or EXEC of LOAD/ALU with I_Flag=0, or EXEC of STORE. Advances only on MEM_RDY=1.
//   Each MEM_RDY=0 cycle increments cnt. cnt==WAIT_LIMIT and MEM_RDY=0 -> BUS_ERR=1, next HALT.
//   MEM_RDY=1 on the limit cycle wins: advance, no error. cnt clears on every phase change.
//  Non-memory phases last exactly 1 cycle. Min instruction = 4 cycles (F,D,E,W).
//  FETCH:  RAM_CS=1, RAM_OE=1; IR_EN=MEM_RDY. Next DECODE.
//  DECODE: PC_EN=1 (one cycle). OPCODE==HALT(4'hF) -> HALT, else EXEC.
//  EXEC / WBACK by opcode (strobes not listed = 0):
//   LOAD 0:  E: I=0 -> RAM_CS,RAM_OE, RDR_EN=MEM_RDY.             W: A_EN
//   STORE 1: E: RAM_CS, ALU_OE (RAM_OE=0, write).                  W: none
//   ALU 2-7 (ADD,SUB,AND,OR,XOR,NOT): E: ALU_EN; I=0 -> RAM_CS,RAM_OE, B_EN=MEM_RDY; I=1 -> B_EN.  W: ALU_OE, A_EN
//   BR 8 (uncond), BZ 9, BN A, BV B, BC C: E: none.   W: PC_LOAD = 1 for BR, else the Z/N/V/C flag bit sampled in WBACK
//   IN D:  E: PORT_EN, PORT_RD.   W: A_EN
//   OUT E: E: PDR_EN.             W: PORT_EN (PORT_RD=0)
//  WBACK -> FETCH. HALT is terminal: strobes 0, HALTED=1; exits only on reset.
//  PC_EN and PC_LOAD are never both 1 in the same cycle.
// STRUCTURE
//  risc_y_pkg: opcode_t enum (LOAD..HALT, 4 bit); phase_t {BOOT,FETCH,DECODE,EXEC,WBACK,HALT} (3 bit);
//   flag index constants FLG_Z/N/V/C; ctrl_t packed struct of the 13 strobes.
//  Sub-module phase_gen_p: state register, wait counter, timeout/BUS_ERR. Top is a pure strobe-decode function of it.
// TESTING
//  Reset: RST=0 mid-EXEC of an ADD -> all 13 strobes 0, PHASE=BOOT; release -> FETCH asserts RAM_CS+RAM_OE one cycle later.
//  LOAD I=0, MEM_RDY held low 3 cycles -> FETCH and EXEC each stretch 4 cycles; IR_EN/RDR_EN pulse once; PC_EN once.
//  BZ with ALU_Flags=4'b0001 -> PC_LOAD=1 in WBACK; ALU_Flags=4'b0000 -> PC_LOAD=0; BR always 1; 4 cycles each.
//  WAIT_LIMIT=3, MEM_RDY=0 forever in FETCH -> BUS_ERR=1, HALTED=1 after 4 wait cycles; MEM_RDY=1 on the 4th -> no error.
//  Ena=1 asserted during EXEC of OUT for 5 cycles -> strobes 0, PHASE held; on deassert PDR_EN resumes, then PORT_EN.
//  OPCODE=4'hF -> HALT after DECODE; stays there with strobes 0 for 20 cycles regardless of MEM_RDY/Ena.

Source files
------------

// File: rtl/risc_y_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_y_pkg
// Description : Shared types for the RISC-Y sequence controller: opcodes,
//               phase codes, ALU flag indices and the datapath strobe bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_y_pkg;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'h0,
    OP_STORE = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_NOT   = 4'h7,
    OP_BR    = 4'h8,
    OP_BZ    = 4'h9,
    OP_BN    = 4'hA,
    OP_BV    = 4'hB,
    OP_BC    = 4'hC,
    OP_IN    = 4'hD,
    OP_OUT   = 4'hE,
    OP_HALT  = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    PH_BOOT   = 3'd0,
    PH_FETCH  = 3'd1,
    PH_DECODE = 3'd2,
    PH_EXEC   = 3'd3,
    PH_WBACK  = 3'd4,
    PH_HALT   = 3'd5
  } phase_t;

  // Bit positions inside ALU_Flags = {C,V,N,Z}
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_V = 2;
  localparam int FLG_C = 3;

  typedef struct packed {
    logic ir_en;
    logic a_en;
    logic b_en;
    logic pdr_en;
    logic port_en;
    logic port_rd;
    logic pc_en;
    logic pc_load;
    logic alu_en;
    logic alu_oe;
    logic ram_oe;
    logic rdr_en;
    logic ram_cs;
  } ctrl_t;

  // ADD..NOT share one execute/writeback pattern
  function automatic logic is_alu_op(input logic [3:0] op);
    is_alu_op = (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

  // A phase is a memory phase when it touches RAM and must wait for MEM_RDY
  function automatic logic is_mem_phase(input logic [2:0] ph,
                                        input logic [3:0] op,
                                        input logic       imm);
    logic res;
    res = 1'b0;
    if (ph == PH_FETCH) begin
      res = 1'b1;
    end else if (ph == PH_EXEC) begin
      res = (op == OP_STORE) || (!imm && ((op == OP_LOAD) || is_alu_op(op)));
    end
    is_mem_phase = res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_gen_p.sv
`default_nettype none
// ============================================================================
// Module      : phase_gen_p
// Description : Instruction phase register for the RISC-Y controller with
//               memory wait-state counting, wait timeout and sticky bus error.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_gen_p
  import risc_y_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic [3:0] opcode,
  input  logic       i_flag,
  input  logic       mem_rdy,
  output logic [2:0] phase,
  output logic       halted,
  output logic       bus_err
);

  // Width floor of 1 keeps the counter legal when the timeout is disabled
  localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  localparam logic [2:0] S_BOOT   = PH_BOOT;
  localparam logic [2:0] S_FETCH  = PH_FETCH;
  localparam logic [2:0] S_DECODE = PH_DECODE;
  localparam logic [2:0] S_EXEC   = PH_EXEC;
  localparam logic [2:0] S_WBACK  = PH_WBACK;
  localparam logic [2:0] S_HALT   = PH_HALT;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [2:0]       succ;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             bus_err_q;
  logic             halted_q;
  logic             err_set;
  logic             mem_phase;
  logic             limit_hit;

  assign mem_phase = is_mem_phase(state_q, opcode, i_flag);

  generate
    if (WAIT_LIMIT > 0) begin : g_timeout
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);
      assign limit_hit = (cnt_q == LIMIT);
    end else begin : g_no_timeout
      assign limit_hit = 1'b0;
    end
  endgenerate

  // Natural successor of each phase once it is allowed to complete
  always_comb begin
    case (state_q)
      S_BOOT:   succ = S_FETCH;
      S_FETCH:  succ = S_DECODE;
      S_DECODE: succ = (opcode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC:   succ = S_WBACK;
      S_WBACK:  succ = S_FETCH;
      S_HALT:   succ = S_HALT;
      default:  succ = S_BOOT;
    endcase
  end

  // Advance, wait or time out; MEM_RDY on the limit cycle takes precedence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    if (!hold) begin
      if (!mem_phase || mem_rdy) begin
        state_d = succ;
        cnt_d   = '0;
      end else if (limit_hit) begin
        state_d = S_HALT;
        cnt_d   = '0;
        err_set = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Phase, wait counter and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_BOOT;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_q | err_set;
      halted_q  <= (state_d == S_HALT);
    end
  end

  assign phase   = state_q;
  assign halted  = halted_q;
  assign bus_err = bus_err_q;

endmodule
`default_nettype wire

// File: rtl/seq_controller_p.sv
`default_nettype none
// ============================================================================
// Module      : seq_controller_p
// Description : RISC-Y sequence controller. Decodes the current phase plus
//               OPCODE/I_Flag/ALU_Flags into the 13 datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_controller_p
  import risc_y_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT  = 15,
  parameter int unsigned USE_MEM_RDY = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Ena,
  input  logic [3:0] OPCODE,
  input  logic       I_Flag,
  input  logic [3:0] ALU_Flags,
  input  logic       MEM_RDY,
  output logic       IR_EN,
  output logic       A_EN,
  output logic       B_EN,
  output logic       PDR_EN,
  output logic       PORT_EN,
  output logic       PORT_RD,
  output logic       PC_EN,
  output logic       PC_LOAD,
  output logic       ALU_EN,
  output logic       ALU_OE,
  output logic       RAM_OE,
  output logic       RDR_EN,
  output logic       RAM_CS,
  output logic [2:0] PHASE,
  output logic       HALTED,
  output logic       BUS_ERR
);

  logic [2:0] phase;
  logic       rdy_eff;
  ctrl_t      ctrl;

  generate
    if (USE_MEM_RDY != 0) begin : g_mem_rdy
      assign rdy_eff = MEM_RDY;
    end else begin : g_no_mem_rdy
      assign rdy_eff = 1'b1;
    end
  endgenerate

  phase_gen_p #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_phase_gen (
    .clk     (CLK),
    .rst_n   (RST),
    .hold    (Ena),
    .opcode  (OPCODE),
    .i_flag  (I_Flag),
    .mem_rdy (rdy_eff),
    .phase   (phase),
    .halted  (HALTED),
    .bus_err (BUS_ERR)
  );

  // Strobe decode; Ena=1 (frozen) forces every strobe low
  always_comb begin
    ctrl = '0;
    case (phase_t'(phase))
      PH_FETCH: begin
        ctrl.ram_cs = 1'b1;
        ctrl.ram_oe = 1'b1;
        ctrl.ir_en  = rdy_eff;
      end
      PH_DECODE: ctrl.pc_en = 1'b1;
      PH_EXEC: begin
        if (is_alu_op(OPCODE)) begin
          ctrl.alu_en = 1'b1;
          if (!I_Flag) begin
            ctrl.ram_cs = 1'b1;
            ctrl.ram_oe = 1'b1;
            ctrl.b_en   = rdy_eff;
          end else begin
            ctrl.b_en   = 1'b1;
          end
        end else begin
          case (opcode_t'(OPCODE))
            OP_LOAD: begin
              if (!I_Flag) begin
                ctrl.ram_cs = 1'b1;
                ctrl.ram_oe = 1'b1;
                ctrl.rdr_en = rdy_eff;
              end
            end
            OP_STORE: begin
              ctrl.ram_cs = 1'b1;
              ctrl.alu_oe = 1'b1;
            end
            OP_IN: begin
              ctrl.port_en = 1'b1;
              ctrl.port_rd = 1'b1;
            end
            OP_OUT:  ctrl.pdr_en = 1'b1;
            default: ctrl = '0;
          endcase
        end
      end
      PH_WBACK: begin
        if (is_alu_op(OPCODE)) begin
          ctrl.alu_oe = 1'b1;
          ctrl.a_en   = 1'b1;
        end else begin
          case (opcode_t'(OPCODE))
            OP_LOAD: ctrl.a_en    = 1'b1;
            OP_BR:   ctrl.pc_load = 1'b1;
            OP_BZ:   ctrl.pc_load = ALU_Flags[FLG_Z];
            OP_BN:   ctrl.pc_load = ALU_Flags[FLG_N];
            OP_BV:   ctrl.pc_load = ALU_Flags[FLG_V];
            OP_BC:   ctrl.pc_load = ALU_Flags[FLG_C];
            OP_IN:   ctrl.a_en    = 1'b1;
            OP_OUT:  ctrl.port_en = 1'b1;
            default: ctrl = '0;
          endcase
        end
      end
      default: ctrl = '0;
    endcase
    if (Ena) begin
      ctrl = '0;
    end
  end

  assign IR_EN   = ctrl.ir_en;
  assign A_EN    = ctrl.a_en;
  assign B_EN    = ctrl.b_en;
  assign PDR_EN  = ctrl.pdr_en;
  assign PORT_EN = ctrl.port_en;
  assign PORT_RD = ctrl.port_rd;
  assign PC_EN   = ctrl.pc_en;
  assign PC_LOAD = ctrl.pc_load;
  assign ALU_EN  = ctrl.alu_en;
  assign ALU_OE  = ctrl.alu_oe;
  assign RAM_OE  = ctrl.ram_oe;
  assign RDR_EN  = ctrl.rdr_en;
  assign RAM_CS  = ctrl.ram_cs;
  assign PHASE   = phase;

endmodule
`default_nettype wire

// File: tb/tb_seq_controller_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_controller_p
// Description : Directed bench for seq_controller_p (WAIT_LIMIT=3). Each
//               stimulus cycle queues its hand-computed expected outputs; a
//               monitor pops and compares mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_controller_p;

  // Strobe bit positions in the compared vector
  localparam logic [12:0] IR  = 13'h1000;
  localparam logic [12:0] AE  = 13'h0800;
  localparam logic [12:0] BE  = 13'h0400;
  localparam logic [12:0] PDR = 13'h0200;
  localparam logic [12:0] PE  = 13'h0100;
  localparam logic [12:0] PRD = 13'h0080;
  localparam logic [12:0] PCE = 13'h0040;
  localparam logic [12:0] PCL = 13'h0020;
  localparam logic [12:0] ALE = 13'h0010;
  localparam logic [12:0] AOE = 13'h0008;
  localparam logic [12:0] ROE = 13'h0004;
  localparam logic [12:0] RDR = 13'h0002;
  localparam logic [12:0] CS  = 13'h0001;
  localparam logic [12:0] NONE = 13'h0000;

  localparam logic [2:0] P_BOOT = 3'd0, P_FETCH = 3'd1, P_DEC = 3'd2,
                         P_EXEC = 3'd3, P_WB = 3'd4, P_HALT = 3'd5;

  localparam logic [3:0] O_LD = 4'h0, O_ST = 4'h1, O_ADD = 4'h2, O_BR = 4'h8,
                         O_BZ = 4'h9, O_BN = 4'hA, O_BV = 4'hB, O_BC = 4'hC,
                         O_IN = 4'hD, O_OUT = 4'hE, O_HLT = 4'hF;

  typedef struct {
    int          tag;
    logic [12:0] strb;
    logic [2:0]  ph;
    logic        hl;
    logic        be;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Ena = 1'b0;
  logic [3:0] OPCODE = 4'h0;
  logic       I_Flag = 1'b0;
  logic [3:0] ALU_Flags = 4'h0;
  logic       MEM_RDY = 1'b1;
  logic IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD, PC_EN, PC_LOAD;
  logic ALU_EN, ALU_OE, RAM_OE, RDR_EN, RAM_CS, HALTED, BUS_ERR;
  logic [2:0] PHASE;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  seq_controller_p #(
    .WAIT_LIMIT  (3),
    .USE_MEM_RDY (1)
  ) dut (
    .CLK (CLK), .RST (RST), .Ena (Ena), .OPCODE (OPCODE), .I_Flag (I_Flag),
    .ALU_Flags (ALU_Flags), .MEM_RDY (MEM_RDY),
    .IR_EN (IR_EN), .A_EN (A_EN), .B_EN (B_EN), .PDR_EN (PDR_EN),
    .PORT_EN (PORT_EN), .PORT_RD (PORT_RD), .PC_EN (PC_EN), .PC_LOAD (PC_LOAD),
    .ALU_EN (ALU_EN), .ALU_OE (ALU_OE), .RAM_OE (RAM_OE), .RDR_EN (RDR_EN),
    .RAM_CS (RAM_CS), .PHASE (PHASE), .HALTED (HALTED), .BUS_ERR (BUS_ERR)
  );

  always #5 CLK = ~CLK;

  // One stimulus cycle: drive inputs just after the edge and queue the expectation
  task automatic cyc(input logic r, input logic e, input logic [3:0] op,
                     input logic i, input logic [3:0] fl, input logic rdy,
                     input logic [12:0] s, input logic [2:0] ph,
                     input logic h, input logic be);
    exp_t x;
    RST = r; Ena = e; OPCODE = op; I_Flag = i; ALU_Flags = fl; MEM_RDY = rdy;
    step_no++;
    x.tag = step_no; x.strb = s; x.ph = ph; x.hl = h; x.be = be;
    sb_q.push_back(x);
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input logic [3:0] op, input logic i, input logic [3:0] fl,
                     input logic rdy, input logic [12:0] s, input logic [2:0] ph);
    cyc(1'b1, 1'b0, op, i, fl, rdy, s, ph, 1'b0, 1'b0);
  endtask

  task automatic br(input logic [3:0] op, input logic [3:0] fl, input logic pcl);
    run(op, 1'b0, fl, 1'b1, CS | ROE | IR, P_FETCH);
    run(op, 1'b0, fl, 1'b1, PCE, P_DEC);
    run(op, 1'b0, fl, 1'b0, NONE, P_EXEC);
    run(op, 1'b0, fl, 1'b0, pcl ? PCL : NONE, P_WB);
  endtask

  // Monitor: compare mid-cycle whenever an expectation is pending
  initial begin
    logic [12:0] act;
    exp_t x;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        x   = sb_q.pop_front();
        act = {IR_EN, A_EN, B_EN, PDR_EN, PORT_EN, PORT_RD, PC_EN, PC_LOAD,
               ALU_EN, ALU_OE, RAM_OE, RDR_EN, RAM_CS};
        n_checks++;
        if (act !== x.strb || PHASE !== x.ph || HALTED !== x.hl || BUS_ERR !== x.be) begin
          n_fail++;
          $display("FAIL step%0d: got strobes=%b phase=%0d halted=%b bus_err=%b, required strobes=%b phase=%0d halted=%b bus_err=%b",
                   x.tag, act, PHASE, HALTED, BUS_ERR, x.strb, x.ph, x.hl, x.be);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge CLK);
    #1;
    // Reset and release
    cyc(1'b0, 1'b0, O_LD, 1'b0, 4'h0, 1'b1, NONE, P_BOOT, 1'b0, 1'b0);
    run(O_LD, 1'b0, 4'h0, 1'b1, NONE, P_BOOT);
    // LOAD I=0, three wait cycles in FETCH and in EXEC (limit cycle rdy wins)
    repeat (3) run(O_LD, 1'b0, 4'h0, 1'b0, CS | ROE, P_FETCH);
    run(O_LD, 1'b0, 4'h0, 1'b1, CS | ROE | IR, P_FETCH);
    run(O_LD, 1'b0, 4'h0, 1'b1, PCE, P_DEC);
    repeat (3) run(O_LD, 1'b0, 4'h0, 1'b0, CS | ROE, P_EXEC);
    run(O_LD, 1'b0, 4'h0, 1'b1, CS | ROE | RDR, P_EXEC);
    run(O_LD, 1'b0, 4'h0, 1'b1, AE, P_WB);
    // ADD I=0 aborted by reset during EXEC
    run(O_ADD, 1'b0, 4'h0, 1'b1, CS | ROE | IR, P_FETCH);
    run(O_ADD, 1'b0, 4'h0, 1'b1, PCE, P_DEC);
    run(O_ADD, 1'b0, 4'h0, 1'b0, ALE | CS | ROE, P_EXEC);
    cyc(1'b0, 1'b0, O_ADD, 1'b0, 4'h0, 1'b0, NONE, P_BOOT, 1'b0, 1'b0);
    run(O_ADD, 1'b1, 4'h0, 1'b1, NONE, P_BOOT);
    // ADD I=1: immediate operand, EXEC does not wait on MEM_RDY
    run(O_ADD, 1'b1, 4'h0, 1'b1, CS | ROE | IR, P_FETCH);
    run(O_ADD, 1'b1, 4'h0, 1'b1, PCE, P_DEC);
    run(O_ADD, 1'b1, 4'h0, 1'b0, ALE | BE, P_EXEC);
    run(O_ADD, 1'b1, 4'h0, 1'b0, AOE | AE, P_WB);
    // Branches
    br(O_BZ, 4'b0001, 1'b1);
    br(O_BZ, 4'b1110, 1'b0);
    br(O_BR, 4'b0000, 1'b1);
    br(O_BN, 4'b0010, 1'b1);
    br(O_BN, 4'b1101, 1'b0);
    br(O_BV, 4'b0100, 1'b1);
    br(O_BC, 4'b1000, 1'b1);
    br(O_BC, 4'b0111, 1'b0);
    // OUT frozen for 5 cycles in EXEC
    run(O_OUT, 1'b0, 4'h0, 1'b1, CS | ROE | IR, P_FETCH);
    run(O_OUT, 1'b0, 4'h0, 1'b1, PCE, P_DEC);
    repeat (5) cyc(1'b1, 1'b1, O_OUT, 1'b0, 4'h0, 1'b1, NONE, P_EXEC, 1'b0, 1'b0);
    run(O_OUT, 1'b0, 4'h0, 1'b1, PDR, P_EXEC);
    run(O_OUT, 1'b0, 4'h0, 1'b1, PE, P_WB);
    // IN
    run(O_IN, 1'b0, 4'h0, 1'b1, CS | ROE | IR, P_FETCH);
    run(O_IN, 1'b0, 4'h0, 1'b1, PCE, P_DEC);
    run(O_IN, 1'b0, 4'h0, 1'b0, PE | PRD, P_EXEC);
    run(O_IN, 1'b0, 4'h0, 1'b0, AE, P_WB);
    // STORE with one wait cycle
    run(O_ST, 1'b1, 4'h0, 1'b1, CS | ROE | IR, P_FETCH);
    run(O_ST, 1'b1, 4'h0, 1'b1, PCE, P_DEC);
    run(O_ST, 1'b1, 4'h0, 1'b0, CS | AOE, P_EXEC);
    run(O_ST, 1'b1, 4'h0, 1'b1, CS | AOE, P_EXEC);
    run(O_ST, 1'b1, 4'h0, 1'b1, NONE, P_WB);
    // Timeout in FETCH: 4 wait cycles then HALT with sticky BUS_ERR
    repeat (4) run(O_LD, 1'b0, 4'h0, 1'b0, CS | ROE, P_FETCH);
    for (int k = 0; k < 6; k++)
      cyc(1'b1, k[0], O_LD, 1'b0, 4'h0, k[1], NONE, P_HALT, 1'b1, 1'b1);
    // Reset clears error; HALT opcode then 20 cycles parked in HALT
    cyc(1'b0, 1'b0, O_HLT, 1'b0, 4'h0, 1'b1, NONE, P_BOOT, 1'b0, 1'b0);
    run(O_HLT, 1'b0, 4'h0, 1'b1, NONE, P_BOOT);
    run(O_HLT, 1'b0, 4'h0, 1'b1, CS | ROE | IR, P_FETCH);
    run(O_HLT, 1'b0, 4'h0, 1'b1, PCE, P_DEC);
    for (int k = 0; k < 20; k++)
      cyc(1'b1, (k % 3) == 0, O_HLT, k[0], 4'(k), k[1], NONE, P_HALT, 1'b1, 1'b0);

    @(negedge CLK);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
